// File: rtl/fp_packer.sv
// fp_packer: multi-cycle normalize / round-to-nearest-even / pack stage that
// turns {sign, biased exponent, wide mantissa with guard/sticky} into an
// IEEE-754 single-precision word. One normalization shift per NORM cycle.
module fp_packer #(
  parameter int MWIDTH = 28,
  parameter int EWIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rest,
  input  logic                     start,
  input  logic                     sign_in,
  input  logic signed [EWIDTH-1:0] exp_in,
  input  logic [MWIDTH-1:0]        mant_in,
  input  logic                     is_nan_in,
  input  logic                     is_inf_in,
  output logic [31:0]              result,
  output logic                     done,
  output logic                     busy,
  output logic                     overflow
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;

  // Exponent constants held at the internal exponent width so every compare
  // and add stays a same-width signed operation.
  localparam logic signed [EWIDTH-1:0] E_ONE    = EWIDTH'(1);
  localparam logic signed [EWIDTH-1:0] E_MAX    = EWIDTH'(255);
  localparam logic signed [EWIDTH-1:0] EXP_TINY = EWIDTH'(-MWIDTH);
  localparam logic [31:0]              QNAN     = 32'h7FC0_0000;

  state_t                     state;

  // operands latched at start, then normalized in place
  logic                       sign_p0;
  logic signed [EWIDTH-1:0]   exp_p0;
  logic [MWIDTH-1:0]          mant_p0;
  logic                       nan_p0;
  logic                       inf_p0;

  // packed word waiting for the OUT cycle
  logic [31:0]                res_p1;
  logic                       ovf_p1;

  logic                       norm_special;
  logic                       norm_zero;
  logic                       norm_tiny;
  logic                       norm_rsh;
  logic                       norm_lsh;
  logic                       norm_shift;

  logic [24:0]                rnd_sum;
  logic [31:0]                rnd_word;
  logic                       rnd_ovf;

  // Round-to-nearest-even on {hidden, fraction}; bit 24 of the return is the
  // carry out of the 24-bit significand.
  function automatic logic [24:0] round_rne(input logic [MWIDTH-2:0] m);
    logic lsb;
    logic grd;
    logic stk;
    logic inc;
    lsb = m[3];
    grd = m[2];
    stk = |m[1:0];
    inc = grd & (stk | lsb);
    return {1'b0, m[MWIDTH-2:3]} + {24'd0, inc};
  endfunction

  // Build the final word from the rounded significand; saturates to infinity
  // (and flags overflow) when the exponent leaves the finite range. The top
  // bit of the return is the overflow flag.
  function automatic logic [32:0] pack_sat(input logic                     s,
                                           input logic signed [EWIDTH-1:0] e,
                                           input logic [24:0]              sum);
    logic signed [EWIDTH-1:0] e_r;
    logic                     hid;
    logic [22:0]              frac;
    if (sum[24]) begin
      e_r  = e + E_ONE;
      hid  = 1'b1;
      frac = 23'd0;
    end else begin
      e_r  = e;
      hid  = sum[23];
      frac = sum[22:0];
    end
    if (hid && (e_r >= E_MAX))
      return {1'b1, s, 8'hFF, 23'd0};
    return {1'b0, s, (hid ? e_r[7:0] : 8'd0), frac};
  endfunction

  assign norm_special = nan_p0 | inf_p0;
  assign norm_zero    = (mant_p0 == '0);
  assign norm_tiny    = (exp_p0 < EXP_TINY);
  assign norm_rsh     = mant_p0[MWIDTH-1] || (exp_p0 < E_ONE);
  assign norm_lsh     = !mant_p0[MWIDTH-2] && (exp_p0 > E_ONE);
  assign norm_shift   = !norm_zero && (norm_tiny || norm_rsh || norm_lsh);

  // ---- round stage: combinational RNE + pack on the normalized operand ----
  assign rnd_sum             = round_rne(mant_p0[MWIDTH-2:0]);
  assign {rnd_ovf, rnd_word} = pack_sat(sign_p0, exp_p0, rnd_sum);

  // Datapath: latch operands, apply one normalization step per NORM cycle,
  // capture the packed word. Data registers carry no reset.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (start) begin
          sign_p0 <= sign_in;
          exp_p0  <= exp_in;
          mant_p0 <= mant_in;
          nan_p0  <= is_nan_in;
          inf_p0  <= is_inf_in;
        end
      end
      NORM: begin
        if (norm_special) begin
          res_p1 <= nan_p0 ? QNAN : {sign_p0, 8'hFF, 23'd0};
          ovf_p1 <= 1'b0;
        end else if (norm_zero) begin
          // zero falls through rounding unchanged and packs as signed zero
        end else if (norm_tiny) begin
          // far below the subnormal range: keep only a sticky bit
          mant_p0 <= MWIDTH'(1);
          exp_p0  <= E_ONE;
        end else if (norm_rsh) begin
          // shift right, jamming the lost bit into sticky
          mant_p0 <= {1'b0, mant_p0[MWIDTH-1:2], mant_p0[1] | mant_p0[0]};
          exp_p0  <= exp_p0 + E_ONE;
        end else if (norm_lsh) begin
          mant_p0 <= {mant_p0[MWIDTH-2:0], 1'b0};
          exp_p0  <= exp_p0 - E_ONE;
        end
      end
      ROUND: begin
        res_p1 <= rnd_word;
        ovf_p1 <= rnd_ovf;
      end
      default: begin
      end
    endcase
  end

  // Control FSM with registered done/busy/result/overflow.
  always_ff @(posedge clk) begin
    if (rest) begin
      state    <= IDLE;
      result   <= 32'd0;
      done     <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            state <= NORM;
          end
        end
        NORM: begin
          if (norm_special)
            state <= OUT;
          else if (!norm_shift)
            state <= ROUND;
        end
        ROUND: begin
          state <= OUT;
        end
        OUT: begin
          result   <= res_p1;
          overflow <= ovf_p1;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_packer.sv
// tb_fp_packer: directed and randomized checks of fp_packer against an
// exact-arithmetic round-to-nearest-even model of the packed result.
module tb_fp_packer;

  logic               clk = 1'b0;
  logic               rest;
  logic               start;
  logic               sign_in;
  logic signed [9:0]  exp_in;
  logic [27:0]        mant_in;
  logic               is_nan_in;
  logic               is_inf_in;
  logic [31:0]        result;
  logic               done;
  logic               busy;
  logic               overflow;

  int errors = 0;
  int checks = 0;

  fp_packer #(.MWIDTH(28), .EWIDTH(10)) dut (
    .clk      (clk),
    .rest     (rest),
    .start    (start),
    .sign_in  (sign_in),
    .exp_in   (exp_in),
    .mant_in  (mant_in),
    .is_nan_in(is_nan_in),
    .is_inf_in(is_inf_in),
    .result   (result),
    .done     (done),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // x / 2^sh rounded to nearest, ties to even; negative sh shifts left
  function automatic longint unsigned rne_shr(input longint unsigned x, input int sh);
    longint unsigned q;
    longint unsigned rem;
    longint unsigned half;
    if (sh <= 0) return x << (-sh);
    q    = x >> sh;
    rem  = x - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    return q;
  endfunction

  // Value is m * 2^(e - 127 - 26). Result is that value rounded exactly; the
  // latency follows from how far the leading one must travel.
  task automatic ref_model(input bit s, input int e, input logic [27:0] m,
                           input bit nan, input bit inf,
                           output logic [31:0] r, output bit ovf, output int lat);
    int p;
    int eb;
    int k;
    longint unsigned q;
    logic [7:0] ef;
    ovf = 1'b0;
    lat = 3;
    p   = -1;
    if (nan) begin r = 32'h7FC0_0000; lat = 2; return; end
    if (inf) begin r = {s, 8'hFF, 23'd0}; lat = 2; return; end
    if (m == 0) begin r = {s, 31'd0}; return; end
    if (e < -28) begin r = {s, 31'd0}; lat = 4; return; end
    for (int i = 0; i < 28; i++) if (m[i]) p = i;
    if (e < 1) k = 1 - e;
    else if (p == 27) k = 1;
    else k = ((26 - p) < (e - 1)) ? (26 - p) : (e - 1);
    lat = 3 + k;
    eb = e + p - 26;
    if (eb >= 1) begin
      q = rne_shr(64'(m), p - 23);
      if (q == (64'd1 << 24)) begin
        q  = 64'd1 << 23;
        eb = eb + 1;
      end
      if (eb >= 255) begin
        r   = {s, 8'hFF, 23'd0};
        ovf = 1'b1;
      end else begin
        ef = eb[7:0];
        r  = {s, ef, q[22:0]};
      end
    end else begin
      q = rne_shr(64'(m), 4 - e);
      r = {s, q[30:0]};
    end
  endtask

  task automatic run_op(input string tag, input bit s, input int e, input logic [27:0] m,
                        input bit nan, input bit inf);
    logic [31:0] er;
    bit          eo;
    int          el;
    int          cyc;
    bit          got;
    ref_model(s, e, m, nan, inf, er, eo, el);
    sign_in   = s;
    exp_in    = 10'(e);
    mant_in   = m;
    is_nan_in = nan;
    is_inf_in = inf;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (done) got = 1'b1;
    end
    chk({tag, ".latency"}, got ? 32'(cyc) : 32'hFFFF_FFFF, 32'(el));
    chk({tag, ".result"}, result, er);
    chk({tag, ".overflow"}, 32'(overflow), 32'(eo));
    chk({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int          cyc;
    int          ndone;
    logic [31:0] first_res;
    int          first_cyc;
    logic [27:0] m;
    int          e;
    int          sel;

    rest      = 1'b1;
    start     = 1'b0;
    sign_in   = 1'b0;
    exp_in    = '0;
    mant_in   = '0;
    is_nan_in = 1'b0;
    is_inf_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.result", result, 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.overflow", 32'(overflow), 32'd0);
    rest = 1'b0;
    @(posedge clk); #1;

    run_op("one",        0, 127, 28'h4000000, 0, 0);
    run_op("lshift4",    0, 127, 28'h0400000, 0, 0);
    run_op("rshift1",    0, 127, 28'h8000000, 0, 0);
    run_op("rshift1_neg",1, 127, 28'h8000000, 0, 0);
    run_op("rne_tie_even",0, 127, 28'h4000004, 0, 0);
    run_op("rne_tie_odd", 0, 127, 28'h400000C, 0, 0);
    run_op("rne_above",  0, 127, 28'h4000005, 0, 0);
    run_op("ovf_carry",  0, 254, 28'h7FFFFFC, 0, 0);
    run_op("subnormal",  0, 0,   28'h4000000, 0, 0);
    run_op("sub_to_min", 0, 1,   28'h3FFFFFC, 0, 0);
    run_op("tiny",       1, -29, 28'hFFFFFFF, 0, 0);
    run_op("edge_m28",   0, -28, 28'h8000000, 0, 0);
    run_op("zero_neg",   1, 127, 28'h0000000, 0, 0);
    run_op("nan",        1, 127, 28'h4000000, 1, 0);
    run_op("nan_inf",    0, 5,   28'h0000000, 1, 1);
    run_op("inf_neg",    1, 3,   28'h1234567, 0, 1);
    run_op("big_exp",    0, 300, 28'h4000000, 0, 0);

    // start while busy must be ignored: one done carrying the first result
    sign_in = 0; exp_in = 10'd127; mant_in = 28'h0400000; is_nan_in = 0; is_inf_in = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; first_res = '0; first_cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      if (c == 2) begin
        mant_in = 28'h8000000; sign_in = 1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (first_cyc < 0) begin first_cyc = c; first_res = result; end
      end
    end
    start = 1'b0;
    chk("busy_start.ndone", 32'(ndone), 32'd1);
    chk("busy_start.result", first_res, 32'h3D80_0000);
    chk("busy_start.latency", 32'(first_cyc), 32'd7);

    // reset during NORM aborts without done
    sign_in = 0; exp_in = 10'd127; mant_in = 28'h0000001;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rest = 1'b1;
    @(posedge clk); #1;
    rest = 1'b0;
    chk("abort.result", result, 32'd0);
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    chk("abort.overflow", 32'(overflow), 32'd0);
    ndone = 0;
    for (cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort.no_done", 32'(ndone), 32'd0);
    run_op("after_abort", 0, 127, 28'h4000000, 0, 0);

    // randomized operands
    for (int n = 0; n < 150; n++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: m = 28'($urandom);
        1: m = 28'($urandom) >> $urandom_range(0, 27);
        2: m = {2'b01, 26'($urandom)};
        default: m = ($urandom_range(0, 3) == 0) ? 28'd0 : 28'($urandom) & 28'h7FFFFFF;
      endcase
      e = int'($urandom_range(0, 340)) - 40;
      sel = int'($urandom_range(0, 15));
      run_op("rand", 1'($urandom), e, m, sel == 0, sel == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
